data_memory_ctrl: RTL and testbench
===================================

Name: data_memory_ctrl

Overview:
- Parametrised single-port synchronous data memory for the CalcuTEC datapath; successor to the fixed 256x32 Memory block.
- Adds:
  - byte-enable writes
  - a registered read with a valid strobe
  - a req/ready handshake
  - a hardware clear sequencer that zeroes the array after reset or on request
  - out-of-range address detection
- Sits between the CPU load/store unit and the storage array.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
ADDR_WIDTH, 8, address bus width in bits.
DEPTH, 256, number of words; must satisfy 2 <= DEPTH <= 2**ADDR_WIDTH.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst_n  input  1  synchronous active-low reset.
req  input  1  transfer request.
we  input  1  1 = write, 0 = read; sampled with req.
addr  input  ADDR_WIDTH  word address.
wdata  input  DATA_WIDTH  write data.
be  input  DATA_WIDTH/8  byte enables; be[i] covers wdata[8i+7:8i].
clr  input  1  request a full clear of the array.
ready  output  1  1 = transfers accepted this cycle.
rdata  output  DATA_WIDTH  read data, registered.
rvalid  output  1  one-cycle pulse when rdata is updated by a read.
err  output  1  one-cycle pulse on an accepted out-of-range access.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n). Sampled only on the rising edge of clk; no asynchronous paths.
- Reset (rst_n=0 at an edge):
  - state <= CLEAR, clr_ptr <= 0.
  - ready=0, rdata=0, rvalid=0, err=0.
  - Array contents are not touched by reset itself.
- State CLEAR:
  - Each edge with rst_n=1 writes 0 to mem[clr_ptr], then clr_ptr++.
  - The edge that clears DEPTH-1 moves to RUN. ready=1 from that edge onward.
  - Clear therefore takes exactly DEPTH edges after reset release.
  - req is ignored: no write, no rvalid, no err.
  - clr=1 during CLEAR restarts: clr_ptr <= 0.
  - Reset during CLEAR restarts from 0.
- State RUN, ready=1: a transfer is accepted on an edge where req=1 and clr=0.
  - Write, addr < DEPTH:
    - For each i with be[i]=1, mem[addr] byte i <= wdata byte i. Other bytes unchanged.
    - be=0 is a legal no-op write.
    - rvalid=0.
  - Read, addr < DEPTH: rdata <= mem[addr] (pre-edge contents); rvalid=1 for the following cycle only.
  - Latency: read data and rvalid are visible 1 cycle after the accepting edge.
  - rdata holds its value until the next accepted read or reset.
  - Out of range, addr >= DEPTH:
    - A write is dropped.
    - A read sets rdata <= 0 with rvalid=1.
    - err=1 for one cycle in both cases.
  - Back-to-back: one transfer per cycle, no bubbles.
  - A read in the cycle after a write to the same address returns the new data.
- clr=1 in RUN:
  - Next state is CLEAR, clr_ptr <= 0, ready <= 0.
  - clr has priority over a simultaneous req: that req is not executed and produces no rvalid or err.
- rvalid and err are deasserted on every edge that does not accept a qualifying transfer.
- The array is inferred as synchronous RAM with a single write port. The clear sequencer and CPU writes share that port through a mux selected by state.

Test Plan:
1. Reset release with DEPTH=256:
   - ready stays 0 for 256 edges, then 1.
   - Reading addr 0, 5 and 255 returns 0 with rvalid=1 one cycle later.
2. Write addresses 0..7 with data 1, 10, 100, ..., 10000000 and be=4'hF, back-to-back, then read 0..7 back-to-back:
   - rdata matches each value 1 cycle after its read.
   - rvalid is high for 8 consecutive cycles.
3. Write addr 5 = 32'h11223344 (be=F), then write addr 5 = 32'hAABBCCDD with be=4'b0101:
   - Read of addr 5 returns 32'h11BB33DD.
   - A write with be=0 leaves the value unchanged.
4. Run with DEPTH=200, ADDR_WIDTH=8:
   - Write to addr 210 gives err pulse, array unchanged.
   - Read of addr 210 gives rdata=0, rvalid=1, err=1.
   - Read of addr 199 returns stored data, err=0.
5. After test 2, assert clr together with req (read addr 3):
   - No rvalid; ready drops next cycle for 256 edges.
   - Afterwards, read of addr 3 returns 0.
   - req held high during CLEAR produces no rvalid.
6. Assert rst_n=0 for one edge midway through a clear (clr_ptr=100):
   - All outputs are 0 after that edge.
   - The clear restarts, and ready returns exactly 256 edges after rst_n returns to 1.

Source files
------------

// File: rtl/data_memory_ctrl.sv
// ---------------------------------------------------------------------------
// data_memory_ctrl
//   Single-port synchronous data memory with byte-enable writes, a registered
//   read with valid strobe, a req/ready handshake, a hardware clear sequencer
//   (runs after reset and on clr) and out-of-range address detection.
//
// Ports
//   clk     in   system clock, rising edge
//   rst_n   in   synchronous active-low reset
//   req     in   transfer request
//   we      in   1 = write, 0 = read
//   addr    in   word address            [ADDR_WIDTH]
//   wdata   in   write data              [DATA_WIDTH]
//   be      in   byte enables            [DATA_WIDTH/8]
//   clr     in   request a full clear of the array
//   ready   out  transfers accepted this cycle
//   rdata   out  registered read data    [DATA_WIDTH]
//   rvalid  out  one-cycle pulse when rdata is updated by a read
//   err     out  one-cycle pulse on an accepted out-of-range access
// ---------------------------------------------------------------------------
module data_memory_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req,
    input  logic                    we,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic                    clr,
    output logic                    ready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    rvalid,
    output logic                    err
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    // Depth expressed one bit wider than the address so DEPTH == 2**ADDR_WIDTH fits.
    localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [ADDR_WIDTH-1:0]   clr_ptr_r;
    logic [ADDR_WIDTH-1:0]   clr_ptr_nxt_s;
    logic                    ready_r;
    logic                    rvalid_r;
    logic                    err_r;
    logic [DATA_WIDTH-1:0]   rdata_r;

    logic                    in_range_s;
    logic                    accept_s;
    logic                    mem_we_s;
    logic [ADDR_WIDTH-1:0]   mem_addr_s;
    logic [DATA_WIDTH-1:0]   mem_wdata_s;
    logic [BE_WIDTH-1:0]     mem_be_s;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    assign in_range_s = ({1'b0, addr} < DEPTH_W);
    // ready_r is high exactly while in RUN, so it also qualifies acceptance.
    assign accept_s   = ready_r & req & ~clr;

    // Next-state logic for the clear sequencer / run FSM.
    always_comb begin
        state_nxt_s   = state_r;
        clr_ptr_nxt_s = clr_ptr_r;
        case (state_r)
            ST_CLEAR: begin
                if (clr) begin
                    clr_ptr_nxt_s = {ADDR_WIDTH{1'b0}};
                end else if (clr_ptr_r == LAST_PTR) begin
                    state_nxt_s   = ST_RUN;
                    clr_ptr_nxt_s = {ADDR_WIDTH{1'b0}};
                end else begin
                    clr_ptr_nxt_s = clr_ptr_r + PTR_ONE;
                end
            end
            ST_RUN: begin
                if (clr) begin
                    state_nxt_s   = ST_CLEAR;
                    clr_ptr_nxt_s = {ADDR_WIDTH{1'b0}};
                end else begin
                    state_nxt_s   = ST_RUN;
                end
            end
            default: begin
                state_nxt_s   = ST_CLEAR;
                clr_ptr_nxt_s = {ADDR_WIDTH{1'b0}};
            end
        endcase
    end

    // Single write port shared by the clear sequencer and CPU writes.
    // Writes are gated by rst_n so a reset edge never alters the array.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_addr_s  = addr;
        mem_wdata_s = wdata;
        mem_be_s    = be;
        if (state_r == ST_CLEAR) begin
            mem_we_s    = rst_n;
            mem_addr_s  = clr_ptr_r;
            mem_wdata_s = {DATA_WIDTH{1'b0}};
            mem_be_s    = {BE_WIDTH{1'b1}};
        end else begin
            mem_we_s    = rst_n & accept_s & we & in_range_s;
        end
    end

    // Storage array: byte-lane write, no reset (cleared by the sequencer).
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            for (int i = 0; i < BE_WIDTH; i++) begin
                if (mem_be_s[i]) begin
                    mem[mem_addr_s][8*i +: 8] <= mem_wdata_s[8*i +: 8];
                end
            end
        end
    end

    // Control state, handshake and registered read/status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_CLEAR;
            clr_ptr_r <= {ADDR_WIDTH{1'b0}};
            ready_r   <= 1'b0;
            rdata_r   <= {DATA_WIDTH{1'b0}};
            rvalid_r  <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            clr_ptr_r <= clr_ptr_nxt_s;
            ready_r   <= (state_nxt_s == ST_RUN);
            rvalid_r  <= accept_s & ~we;
            err_r     <= accept_s & ~in_range_s;
            if (accept_s && !we) begin
                // Out-of-range reads return zero rather than aliasing.
                rdata_r <= in_range_s ? mem[addr] : {DATA_WIDTH{1'b0}};
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    assign ready  = ready_r;
    assign rdata  = rdata_r;
    assign rvalid = rvalid_r;
    assign err    = err_r;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench for data_memory_ctrl: a DEPTH=256 instance driven with
// random and directed traffic against a behavioural model, plus a DEPTH=200
// instance for out-of-range behaviour.
module tb_data_memory_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0, we = 1'b0, clr = 1'b0;
    logic [7:0]  addr = 8'd0;
    logic [31:0] wdata = 32'd0;
    logic [3:0]  be = 4'd0;
    logic        ready, rvalid, err;
    logic [31:0] rdata;

    logic        req_b = 1'b0, we_b = 1'b0, clr_b = 1'b0;
    logic [7:0]  addr_b = 8'd0;
    logic [31:0] wdata_b = 32'd0;
    logic [3:0]  be_b = 4'd0;
    logic        ready_b, rvalid_b, err_b;
    logic [31:0] rdata_b;

    int total = 0;
    int bad = 0;

    // behavioural model of the DEPTH=256 instance
    logic [31:0] m_mem [256];
    int          m_cnt = 0;
    bit          m_run = 1'b0;
    logic        e_ready = 1'b0, e_rvalid = 1'b0, e_err = 1'b0;
    logic [31:0] e_rdata = 32'd0;

    always #5 clk = ~clk;

    data_memory_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .be(be), .clr(clr), .ready(ready), .rdata(rdata),
        .rvalid(rvalid), .err(err)
    );

    data_memory_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(200)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .we(we_b), .addr(addr_b),
        .wdata(wdata_b), .be(be_b), .clr(clr_b), .ready(ready_b), .rdata(rdata_b),
        .rvalid(rvalid_b), .err(err_b)
    );

    // Drive one cycle on instance A, advance the model, sample 1 time unit later.
    task automatic step(input logic r, input logic w, input logic [7:0] a,
                        input logic [31:0] d, input logic [3:0] b, input logic c);
        req = r; we = w; addr = a; wdata = d; be = b; clr = c;
        @(posedge clk);
        if (!rst_n) begin
            m_run = 1'b0; m_cnt = 0;
            e_rdata = 32'd0; e_rvalid = 1'b0; e_err = 1'b0;
        end else if (!m_run) begin
            e_rvalid = 1'b0; e_err = 1'b0;
            if (c) begin
                m_cnt = 0;
            end else begin
                m_mem[m_cnt] = 32'd0;
                m_cnt++;
                if (m_cnt == 256) m_run = 1'b1;
            end
        end else if (c) begin
            m_run = 1'b0; m_cnt = 0; e_rvalid = 1'b0; e_err = 1'b0;
        end else if (r) begin
            e_err = 1'b0;
            e_rvalid = !w;
            if (w) begin
                for (int i = 0; i < 4; i++)
                    if (b[i]) m_mem[a][8*i +: 8] = d[8*i +: 8];
            end else begin
                e_rdata = m_mem[a];
            end
        end else begin
            e_rvalid = 1'b0; e_err = 1'b0;
        end
        e_ready = m_run;
        #1;
    endtask

    task automatic set_b(input logic r, input logic w, input logic [7:0] a,
                         input logic [31:0] d, input logic [3:0] b);
        req_b = r; we_b = w; addr_b = a; wdata_b = d; be_b = b;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step(1'b0, 1'b0, 8'd0, 32'd0, 4'd0, 1'b0);
        step(1'b0, 1'b0, 8'd0, 32'd0, 4'd0, 1'b0);
        total++;
        if (ready !== 1'b0 || rvalid !== 1'b0 || err !== 1'b0 || rdata !== 32'd0) begin
            bad++;
            $display("FAIL reset_state: got r=%b v=%b e=%b d=%h want all zero", ready, rvalid, err, rdata);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 256; i++) begin
            step(1'($urandom), 1'($urandom), 8'($urandom), $urandom, 4'($urandom), 1'b0);
            total++;
            if (ready !== e_ready || rvalid !== e_rvalid || err !== e_err || rdata !== e_rdata) begin
                bad++;
                $display("FAIL init_clear[%0d]: got r=%b v=%b e=%b d=%h want r=%b v=%b e=%b d=%h",
                         i, ready, rvalid, err, rdata, e_ready, e_rvalid, e_err, e_rdata);
            end
            total++;
            if (ready !== (i == 255)) begin
                bad++;
                $display("FAIL init_ready_edge[%0d]: got %b want %b", i, ready, (i == 255));
            end
        end
        for (int k = 0; k < 3; k++) begin
            logic [7:0] ra;
            ra = (k == 0) ? 8'd0 : (k == 1) ? 8'd5 : 8'd255;
            step(1'b1, 1'b0, ra, 32'd0, 4'd0, 1'b0);
            total++;
            if (rdata !== 32'd0 || rvalid !== 1'b1 || err !== 1'b0) begin
                bad++;
                $display("FAIL cleared_read[%0d]: got d=%h v=%b e=%b want d=0 v=1 e=0", ra, rdata, rvalid, err);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] v;
        v = 32'd1;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 8'(i), v, 4'hF, 1'b0);
            v = v * 32'd10;
        end
        v = 32'd1;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 8'(i), 32'd0, 4'd0, 1'b0);
            total++;
            if (rdata !== v || rvalid !== 1'b1 || rdata !== e_rdata) begin
                bad++;
                $display("FAIL b2b_read[%0d]: got d=%h v=%b want d=%h v=1", i, rdata, rvalid, v);
            end
            v = v * 32'd10;
        end
        step(1'b0, 1'b0, 8'd0, 32'd0, 4'd0, 1'b0);
        total++;
        if (rvalid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle: got v=%b want v=0", rvalid);
        end
    endtask

    task automatic test_byte_enable;
        step(1'b1, 1'b1, 8'd5, 32'h11223344, 4'hF, 1'b0);
        step(1'b1, 1'b1, 8'd5, 32'hAABBCCDD, 4'b0101, 1'b0);
        step(1'b1, 1'b0, 8'd5, 32'd0, 4'd0, 1'b0);
        total++;
        if (rdata !== 32'h11BB33DD || rvalid !== 1'b1) begin
            bad++;
            $display("FAIL be_merge: got d=%h v=%b want d=11bb33dd v=1", rdata, rvalid);
        end
        step(1'b1, 1'b1, 8'd5, 32'hFFFFFFFF, 4'b0000, 1'b0);
        total++;
        if (rvalid !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL be_zero_write_flags: got v=%b e=%b want 0 0", rvalid, err);
        end
        step(1'b1, 1'b0, 8'd5, 32'd0, 4'd0, 1'b0);
        total++;
        if (rdata !== 32'h11BB33DD || rdata !== e_rdata) begin
            bad++;
            $display("FAIL be_zero_noop: got d=%h want d=11bb33dd", rdata);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 300; i++) begin
            logic [7:0] ra;
            ra = 8'($urandom_range(0, 15));
            if (i % 10 == 9) begin
                // write then read the same address in the next cycle
                step(1'b1, 1'b1, ra, $urandom, 4'($urandom), 1'b0);
                step(1'b1, 1'b0, ra, 32'd0, 4'd0, 1'b0);
            end else begin
                step(1'($urandom), 1'($urandom), ra, $urandom, 4'($urandom), 1'b0);
            end
            total++;
            if (ready !== e_ready || rvalid !== e_rvalid || err !== e_err || rdata !== e_rdata) begin
                bad++;
                $display("FAIL random[%0d]: got r=%b v=%b e=%b d=%h want r=%b v=%b e=%b d=%h",
                         i, ready, rvalid, err, rdata, e_ready, e_rvalid, e_err, e_rdata);
            end
        end
    endtask

    task automatic test_clear_priority;
        step(1'b1, 1'b1, 8'd3, 32'hCAFE0003, 4'hF, 1'b0);
        step(1'b1, 1'b0, 8'd3, 32'd0, 4'd0, 1'b1);
        total++;
        if (rvalid !== 1'b0 || err !== 1'b0 || ready !== 1'b0) begin
            bad++;
            $display("FAIL clr_priority: got v=%b e=%b r=%b want 0 0 0", rvalid, err, ready);
        end
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 1'($urandom), 8'd3, $urandom, 4'hF, 1'b0);
            total++;
            if (ready !== (i == 255) || rvalid !== 1'b0 || err !== 1'b0 || rdata !== e_rdata) begin
                bad++;
                $display("FAIL clr_seq[%0d]: got r=%b v=%b e=%b d=%h want r=%b v=0 e=0 d=%h",
                         i, ready, rvalid, err, rdata, (i == 255), e_rdata);
            end
        end
        step(1'b1, 1'b0, 8'd3, 32'd0, 4'd0, 1'b0);
        total++;
        if (rdata !== 32'd0 || rvalid !== 1'b1) begin
            bad++;
            $display("FAIL clr_result: got d=%h v=%b want d=0 v=1", rdata, rvalid);
        end
    endtask

    task automatic test_reset_mid_clear;
        logic [31:0] v;
        v = $urandom | 32'h1;
        step(1'b1, 1'b1, 8'd9, v, 4'hF, 1'b0);
        step(1'b1, 1'b0, 8'd9, 32'd0, 4'd0, 1'b0);
        step(1'b0, 1'b0, 8'd0, 32'd0, 4'd0, 1'b1);
        for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 8'd0, 32'd0, 4'd0, 1'b0);
        total++;
        if (rdata !== v || ready !== 1'b0 || rdata !== e_rdata) begin
            bad++;
            $display("FAIL mid_clear_hold: got d=%h r=%b want d=%h r=0", rdata, ready, v);
        end
        rst_n = 1'b0;
        step(1'b0, 1'b0, 8'd0, 32'd0, 4'd0, 1'b0);
        total++;
        if (ready !== 1'b0 || rvalid !== 1'b0 || err !== 1'b0 || rdata !== 32'd0) begin
            bad++;
            $display("FAIL mid_clear_reset: got r=%b v=%b e=%b d=%h want all zero", ready, rvalid, err, rdata);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 1'b0, 8'($urandom), 32'd0, 4'd0, 1'b0);
            total++;
            if (ready !== (i == 255) || rvalid !== 1'b0 || ready !== e_ready) begin
                bad++;
                $display("FAIL restart_clear[%0d]: got r=%b v=%b want r=%b v=0", i, ready, rvalid, (i == 255));
            end
        end
        step(1'b1, 1'b0, 8'd9, 32'd0, 4'd0, 1'b0);
        total++;
        if (rdata !== 32'd0 || rvalid !== 1'b1) begin
            bad++;
            $display("FAIL restart_result: got d=%h v=%b want d=0 v=1", rdata, rvalid);
        end
    endtask

    task automatic test_out_of_range;
        logic [31:0] v199, v10;
        v199 = $urandom;
        v10  = $urandom | 32'h1;
        for (int i = 0; i < 300 && ready_b !== 1'b1; i++) step(1'b0, 1'b0, 8'd0, 32'd0, 4'd0, 1'b0);
        total++;
        if (ready_b !== 1'b1) begin
            bad++;
            $display("FAIL oor_ready_timeout: got r=%b want r=1", ready_b);
        end
        set_b(1'b1, 1'b1, 8'd199, v199, 4'hF);
        step(1'b0, 1'b0, 8'd0, 32'd0, 4'd0, 1'b0);
        total++;
        if (err_b !== 1'b0 || rvalid_b !== 1'b0) begin
            bad++;
            $display("FAIL oor_inrange_write: got e=%b v=%b want 0 0", err_b, rvalid_b);
        end
        set_b(1'b1, 1'b1, 8'd10, v10, 4'hF);
        step(1'b0, 1'b0, 8'd0, 32'd0, 4'd0, 1'b0);
        set_b(1'b1, 1'b1, 8'd210, ~v10, 4'hF);
        step(1'b0, 1'b0, 8'd0, 32'd0, 4'd0, 1'b0);
        total++;
        if (err_b !== 1'b1 || rvalid_b !== 1'b0) begin
            bad++;
            $display("FAIL oor_write: got e=%b v=%b want e=1 v=0", err_b, rvalid_b);
        end
        set_b(1'b1, 1'b0, 8'd210, 32'd0, 4'd0);
        step(1'b0, 1'b0, 8'd0, 32'd0, 4'd0, 1'b0);
        total++;
        if (err_b !== 1'b1 || rvalid_b !== 1'b1 || rdata_b !== 32'd0) begin
            bad++;
            $display("FAIL oor_read: got e=%b v=%b d=%h want e=1 v=1 d=0", err_b, rvalid_b, rdata_b);
        end
        set_b(1'b1, 1'b0, 8'd199, 32'd0, 4'd0);
        step(1'b0, 1'b0, 8'd0, 32'd0, 4'd0, 1'b0);
        total++;
        if (err_b !== 1'b0 || rvalid_b !== 1'b1 || rdata_b !== v199) begin
            bad++;
            $display("FAIL oor_last_read: got e=%b v=%b d=%h want e=0 v=1 d=%h", err_b, rvalid_b, rdata_b, v199);
        end
        set_b(1'b1, 1'b0, 8'd10, 32'd0, 4'd0);
        step(1'b0, 1'b0, 8'd0, 32'd0, 4'd0, 1'b0);
        total++;
        if (rdata_b !== v10 || err_b !== 1'b0) begin
            bad++;
            $display("FAIL oor_no_alias: got d=%h e=%b want d=%h e=0", rdata_b, err_b, v10);
        end
        set_b(1'b0, 1'b0, 8'd0, 32'd0, 4'd0);
        step(1'b0, 1'b0, 8'd0, 32'd0, 4'd0, 1'b0);
        total++;
        if (rvalid_b !== 1'b0 || err_b !== 1'b0) begin
            bad++;
            $display("FAIL oor_idle: got v=%b e=%b want 0 0", rvalid_b, err_b);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) m_mem[i] = 32'd0;
        test_reset;
        test_back_to_back;
        test_byte_enable;
        test_random;
        test_clear_priority;
        test_reset_mid_clear;
        test_out_of_range;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
